pipeline_ctrl: RTL and testbench

- Pipeline control for the 5-stage RV32 core (IF, ID, EX, MA, WB).
- Sits directly downstream of the hazard unit. Consumes its unrecoverable data-hazard flag together with branch-resolution and cache-miss events.
- Produces per-stage register enables, bubble/flush strobes and the PC redirect strobe.
- Keeps a post-reset pipeline fill sequence and saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 48 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 94 +++++++++
 tb/tb_pipeline_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the RV32 pipeline controller
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEFAULT       = 32;
    localparam int FILL_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // Stage-control bundle, MSB first: enables IF..WB, then strobes.
    typedef struct packed {
        logic if_ce;
        logic id_ce;
        logic ex_ce;
        logic ma_ce;
        logic wb_ce;
        logic id_flush;
        logic ex_flush;
        logic pc_redirect;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FILL = stage_ctrl_t'(8'b1111_1110);
    localparam stage_ctrl_t CTRL_HOLD = stage_ctrl_t'(8'b0000_0000);
    localparam stage_ctrl_t CTRL_FLOW = stage_ctrl_t'(8'b1111_1000);

    // Event decode for a cycle in which MA can complete.
    function automatic stage_ctrl_t ctrl_decode(input logic hz, input logic br, input logic ic);
        stage_ctrl_t c;
        c = CTRL_FLOW;
        if (br) begin
            c.id_flush    = 1'b1;
            c.ex_flush    = 1'b1;
            c.pc_redirect = 1'b1;
        end else if (hz) begin
            c.if_ce    = 1'b0;
            c.id_ce    = 1'b0;
            c.ex_flush = 1'b1;
        end else if (ic) begin
            c.if_ce    = 1'b0;
            c.id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter with async active-low clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stage enables, bubbles and redirect for the 5-stage RV32 core
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FILL_CYCLES = FILL_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hz_data,
    input  logic             i_br_taken,
    input  logic             i_ic_miss,
    input  logic             i_dc_miss,
    output logic             o_if_ce,
    output logic             o_id_ce,
    output logic             o_ex_ce,
    output logic             o_ma_ce,
    output logic             o_wb_ce,
    output logic             o_id_flush,
    output logic             o_ex_flush,
    output logic             o_pc_redirect,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_t      state_q, state_d;
    logic [3:0]  fill_q, fill_d;
    stage_ctrl_t ctrl;
    logic        stall_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= 4'(FILL_CYCLES - 1);
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        ctrl    = CTRL_FILL;
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            ST_FILL: begin
                if (fill_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    fill_d = fill_q - 4'd1;
                end
            end
            ST_RUN, ST_FREEZE: begin
                // A data miss freezes everything; on release the held EX branch redirects once.
                if (i_dc_miss) begin
                    ctrl    = CTRL_HOLD;
                    state_d = ST_FREEZE;
                end else begin
                    ctrl    = ctrl_decode(i_hz_data, i_br_taken, i_ic_miss);
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign o_if_ce       = ctrl.if_ce;
    assign o_id_ce       = ctrl.id_ce;
    assign o_ex_ce       = ctrl.ex_ce;
    assign o_ma_ce       = ctrl.ma_ce;
    assign o_wb_ce       = ctrl.wb_ce;
    assign o_id_flush    = ctrl.id_flush;
    assign o_ex_flush    = ctrl.ex_flush;
    assign o_pc_redirect = ctrl.pc_redirect;

    assign stall_inc = (state_q != ST_FILL) && !ctrl.if_ce;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (stall_inc),
        .count (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (ctrl.pc_redirect),
        .count (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int FILL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hz = 1'b0, br = 1'b0, ic = 1'b0, dc = 1'b0;

    logic if_ce, id_ce, ex_ce, ma_ce, wb_ce, id_flush, ex_flush, pc_redirect;
    logic [31:0] stall_cnt, flush_cnt;
    logic if_ce4, id_ce4, ex_ce4, ma_ce4, wb_ce4, id_flush4, ex_flush4, pc_redirect4;
    logic [3:0] stall_cnt4, flush_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    int          fill_left;
    longint      m_stall, m_flush, m_stall4, m_flush4;
    logic [7:0]  exp_ctrl;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FILL_CYCLES(FILL), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_hz_data(hz), .i_br_taken(br), .i_ic_miss(ic), .i_dc_miss(dc),
        .o_if_ce(if_ce), .o_id_ce(id_ce), .o_ex_ce(ex_ce), .o_ma_ce(ma_ce), .o_wb_ce(wb_ce),
        .o_id_flush(id_flush), .o_ex_flush(ex_flush), .o_pc_redirect(pc_redirect),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.FILL_CYCLES(FILL), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_hz_data(hz), .i_br_taken(br), .i_ic_miss(ic), .i_dc_miss(dc),
        .o_if_ce(if_ce4), .o_id_ce(id_ce4), .o_ex_ce(ex_ce4), .o_ma_ce(ma_ce4), .o_wb_ce(wb_ce4),
        .o_id_flush(id_flush4), .o_ex_flush(ex_flush4), .o_pc_redirect(pc_redirect4),
        .o_stall_cnt(stall_cnt4), .o_flush_cnt(flush_cnt4)
    );

    function automatic logic [7:0] obs();
        return {if_ce, id_ce, ex_ce, ma_ce, wb_ce, id_flush, ex_flush, pc_redirect};
    endfunction

    // Expected controls from the rule table; order: if,id,ex,ma,wb,id_flush,ex_flush,redirect.
    function automatic logic [7:0] model_ctrl(input bit h, input bit b, input bit i, input bit d);
        if (fill_left > 0) return 8'b1111_1110;
        if (d)             return 8'b0000_0000;
        if (b)             return 8'b1111_1111;
        if (h)             return 8'b0011_1010;
        if (i)             return 8'b0111_1100;
        return 8'b1111_1000;
    endfunction

    task automatic model_clear();
        fill_left = FILL;
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    endtask

    task automatic drive(input bit h, input bit b, input bit i, input bit d);
        hz = h; br = b; ic = i; dc = d;
        #2;
        exp_ctrl = model_ctrl(h, b, i, d);
    endtask

    task automatic advance();
        if (fill_left > 0) begin
            fill_left--;
        end else begin
            if (!exp_ctrl[7]) begin
                if (m_stall  < 64'hFFFF_FFFF) m_stall++;
                if (m_stall4 < 15)            m_stall4++;
            end
            if (exp_ctrl[0]) begin
                if (m_flush  < 64'hFFFF_FFFF) m_flush++;
                if (m_flush4 < 15)            m_flush4++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        hz = 0; br = 0; ic = 0; dc = 0;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        model_clear();
        n_checks++;
        if (obs() !== 8'b1111_1110) begin
            n_fail++; $display("FAIL reset_ctrl got=%b want=%b", obs(), 8'b1111_1110);
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        release_reset();
    endtask

    task automatic test_fill();
        for (int c = 0; c < FILL; c++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if (obs() !== exp_ctrl) begin
                n_fail++; $display("FAIL fill_ctrl cyc=%0d got=%b want=%b", c, obs(), exp_ctrl);
            end
            advance();
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL fill_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        drive(0, 0, 0, 0);
        n_checks++;
        if (obs() !== 8'b1111_1000) begin
            n_fail++; $display("FAIL fill_to_run got=%b want=%b", obs(), 8'b1111_1000);
        end
        advance();
    endtask

    task automatic test_hazard();
        longint s0 = m_stall;
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 0, 0);
            n_checks++;
            if (obs() !== exp_ctrl) begin
                n_fail++; $display("FAIL hazard_ctrl cyc=%0d got=%b want=%b", c, obs(), exp_ctrl);
            end
            advance();
        end
        n_checks++;
        if (stall_cnt !== 32'(s0 + 2)) begin
            n_fail++; $display("FAIL hazard_stall got=%0d want=%0d", stall_cnt, s0 + 2);
        end
    endtask

    task automatic test_branch_combo();
        longint s0 = m_stall;
        longint f0 = m_flush;
        drive(1, 1, 1, 0);
        n_checks++;
        if (obs() !== 8'b1111_1111) begin
            n_fail++; $display("FAIL branch_ctrl got=%b want=%b", obs(), 8'b1111_1111);
        end
        advance();
        hz = 0; br = 0; ic = 0;
        n_checks++;
        if (flush_cnt !== 32'(f0 + 1) || stall_cnt !== 32'(s0)) begin
            n_fail++; $display("FAIL branch_cnt got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
        end
    endtask

    task automatic test_freeze_branch();
        longint s0 = m_stall;
        longint f0 = m_flush;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 1);
            n_checks++;
            if (obs() !== 8'b0000_0000) begin
                n_fail++; $display("FAIL freeze_ctrl cyc=%0d got=%b want=%b", c, obs(), 8'b0);
            end
            advance();
        end
        drive(0, 1, 0, 0);
        n_checks++;
        if (obs() !== 8'b1111_1111) begin
            n_fail++; $display("FAIL freeze_release got=%b want=%b", obs(), 8'b1111_1111);
        end
        advance();
        drive(0, 0, 0, 0);
        n_checks++;
        if (obs() !== exp_ctrl) begin
            n_fail++; $display("FAIL freeze_after got=%b want=%b", obs(), exp_ctrl);
        end
        advance();
        n_checks++;
        if (flush_cnt !== 32'(f0 + 1) || stall_cnt !== 32'(s0 + 3)) begin
            n_fail++; $display("FAIL freeze_cnt got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0 + 3);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            n_checks++;
            if (obs() !== exp_ctrl) begin
                n_fail++; $display("FAIL random_ctrl cyc=%0d got=%b want=%b", c, obs(), exp_ctrl);
            end
            advance();
        end
        n_checks++;
        if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush)) begin
            n_fail++; $display("FAIL random_cnt got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
        end
    endtask

    task automatic test_reset_mid_freeze();
        drive(0, 0, 0, 1);
        advance();
        drive(0, 1, 0, 1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 8'b1111_1110) begin
            n_fail++; $display("FAIL midreset_ctrl got=%b want=%b", obs(), 8'b1111_1110);
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin
            n_fail++; $display("FAIL midreset_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, stall_cnt4);
        end
        release_reset();
    endtask

    task automatic test_saturation();
        for (int c = 0; c < FILL; c++) begin
            drive(0, 0, 0, 0);
            advance();
        end
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 1, 0);
            n_checks++;
            if (obs() !== exp_ctrl) begin
                n_fail++; $display("FAIL sat_ctrl cyc=%0d got=%b want=%b", c, obs(), exp_ctrl);
            end
            advance();
        end
        n_checks++;
        if (stall_cnt4 !== 4'd15) begin
            n_fail++; $display("FAIL sat_cnt4 got=%0d want=15", stall_cnt4);
        end
        n_checks++;
        if (stall_cnt !== 32'(m_stall)) begin
            n_fail++; $display("FAIL sat_cnt32 got=%0d want=%0d", stall_cnt, m_stall);
        end
        drive(0, 0, 1, 0);
        advance();
        n_checks++;
        if (stall_cnt4 !== 4'(m_stall4) || stall_cnt4 !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold got=%0d want=15", stall_cnt4);
        end
        ic = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hazard();
        test_branch_combo();
        test_freeze_branch();
        test_random();
        test_reset_mid_freeze();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
